// File: rtl/ddr5_cmd_responder.sv
// DDR5 DIMM-side command responder.
// Accepts the scheduler's two-cycle command stream (ACT0/ACT1, RD0/RD1,
// WR0/WR1, single-cycle PRE), tracks per-bank open state and timestamps,
// flags protocol and timing violations, and returns a read-valid pulse
// TCAS cycles after every accepted RD0.
module ddr5_cmd_responder #(
    parameter int unsigned TRCD      = 39,
    parameter int unsigned TRAS      = 76,
    parameter int unsigned TRP       = 39,
    parameter int unsigned TRRD_L    = 12,
    parameter int unsigned TRRD_S    = 8,
    parameter int unsigned TCAS      = 40,
    parameter int unsigned RDQ_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd_code,
    input  logic [3:0]  cmd_core,
    input  logic [2:0]  cmd_bg,
    input  logic [1:0]  cmd_ba,
    input  logic [15:0] cmd_row,
    input  logic [9:0]  cmd_col,
    output logic        rd_valid,
    output logic [3:0]  rd_core,
    output logic [2:0]  rd_bg,
    output logic [1:0]  rd_ba,
    output logic [9:0]  rd_col,
    output logic        err_valid,
    output logic [3:0]  err_code,
    output logic [31:0] bank_open
);

    localparam logic [2:0] CMD_ACT0 = 3'd0;
    localparam logic [2:0] CMD_RD0  = 3'd2;
    localparam logic [2:0] CMD_WR0  = 3'd4;
    localparam logic [2:0] CMD_PRE  = 3'd6;

    localparam logic [3:0] ERR_ACT_OPEN  = 4'd1;
    localparam logic [3:0] ERR_TRP       = 4'd2;
    localparam logic [3:0] ERR_TRRD      = 4'd3;
    localparam logic [3:0] ERR_PAIRING   = 4'd4;
    localparam logic [3:0] ERR_CAS_CLOSE = 4'd5;
    localparam logic [3:0] ERR_TRCD      = 4'd6;
    localparam logic [3:0] ERR_TRAS      = 4'd7;
    localparam logic [3:0] ERR_RDQ_FULL  = 4'd8;

    localparam int QW = (RDQ_DEPTH > 1) ? $clog2(RDQ_DEPTH) : 1;
    localparam logic [QW:0] Q_FULL = (QW+1)'(RDQ_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GAP,
        ST_EXPECT
    } state_t;

    state_t state_reg, state_next;

    logic [31:0] now_reg;
    logic [31:0] bank_open_reg;

    // First half of the pair in flight, plus the cycle it arrived on
    logic [2:0]  cap_code_reg;
    logic [3:0]  cap_core_reg;
    logic [2:0]  cap_bg_reg;
    logic [1:0]  cap_ba_reg;
    logic [15:0] cap_row_reg;
    logic [9:0]  cap_col_reg;
    logic [31:0] cap_t_reg;

    // Per-bank timestamps with their valid bits
    logic [31:0] act0_stamp [0:31];
    logic [31:0] act1_stamp [0:31];
    logic [31:0] pre_stamp  [0:31];
    logic [15:0] open_row   [0:31];
    logic [31:0] act0_vld_reg;
    logic [31:0] act1_vld_reg;
    logic [31:0] pre_vld_reg;

    // Most recent committed ACT anywhere, for tRRD
    logic [31:0] last_act_reg;
    logic [2:0]  last_bg_reg;
    logic        last_vld_reg;

    logic        err_valid_reg;
    logic [3:0]  err_code_reg;

    // Read return queue
    logic [3:0]  q_core [0:RDQ_DEPTH-1];
    logic [2:0]  q_bg   [0:RDQ_DEPTH-1];
    logic [1:0]  q_ba   [0:RDQ_DEPTH-1];
    logic [9:0]  q_col  [0:RDQ_DEPTH-1];
    logic [31:0] q_due  [0:RDQ_DEPTH-1];
    logic [QW-1:0] head_reg, tail_reg;
    logic [QW:0]   count_reg;

    logic [4:0]  cmd_idx, cap_idx;
    logic [31:0] since_pre, since_act0, since_act1, since_last;
    logic        fail_open, fail_trp, fail_trrd, fail_closed, fail_trcd, fail_tras;
    logic        pair_match;
    logic        q_pop, q_room;
    logic        do_capture, do_act, do_pre, do_push;
    logic        err_set;
    logic [3:0]  err_set_code;

    function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] p);
        if (p == QW'(RDQ_DEPTH - 1))
            return '0;
        else
            return p + 1'b1;
    endfunction

    assign cmd_idx = {cmd_bg, cmd_ba};
    assign cap_idx = {cap_bg_reg, cap_ba_reg};

    // Elapsed times are modulo 2^32; an invalid stamp never fails a check
    assign since_pre  = now_reg - pre_stamp[cmd_idx];
    assign since_act0 = now_reg - act0_stamp[cmd_idx];
    assign since_act1 = now_reg - act1_stamp[cmd_idx];
    assign since_last = now_reg - last_act_reg;

    assign fail_open   = bank_open_reg[cmd_idx];
    assign fail_closed = !bank_open_reg[cmd_idx];
    assign fail_trp    = pre_vld_reg[cmd_idx]  && (since_pre  < TRP);
    assign fail_trcd   = act1_vld_reg[cmd_idx] && (since_act1 < TRCD);
    assign fail_tras   = act0_vld_reg[cmd_idx] && (since_act0 < TRAS);
    assign fail_trrd   = last_vld_reg &&
                         (since_last < ((cmd_bg == last_bg_reg) ? TRRD_L : TRRD_S));

    assign pair_match = cmd_valid &&
                        (cmd_code == cap_code_reg + 3'd1) &&
                        (cmd_bg   == cap_bg_reg) &&
                        (cmd_ba   == cap_ba_reg) &&
                        (cmd_core == cap_core_reg);

    // The head read returns exactly when its due time arrives
    assign q_pop  = (count_reg != '0) && (q_due[head_reg] == now_reg);
    assign q_room = (count_reg < Q_FULL) || q_pop;

    // Pairing FSM: next state, commit strobes and error selection
    always_comb begin
        state_next   = state_reg;
        do_capture   = 1'b0;
        do_act       = 1'b0;
        do_pre       = 1'b0;
        do_push      = 1'b0;
        err_set      = 1'b0;
        err_set_code = '0;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_code)
                        CMD_ACT0: begin
                            if (fail_open) begin
                                err_set      = 1'b1;
                                err_set_code = ERR_ACT_OPEN;
                            end else if (fail_trp) begin
                                err_set      = 1'b1;
                                err_set_code = ERR_TRP;
                            end else if (fail_trrd) begin
                                err_set      = 1'b1;
                                err_set_code = ERR_TRRD;
                            end else begin
                                do_capture = 1'b1;
                                state_next = ST_GAP;
                            end
                        end
                        CMD_RD0, CMD_WR0: begin
                            if (fail_closed) begin
                                err_set      = 1'b1;
                                err_set_code = ERR_CAS_CLOSE;
                            end else if (fail_trcd) begin
                                err_set      = 1'b1;
                                err_set_code = ERR_TRCD;
                            end else begin
                                do_capture = 1'b1;
                                state_next = ST_GAP;
                            end
                        end
                        CMD_PRE: begin
                            // PRE to a closed bank is a silent no-op
                            if (fail_open) begin
                                if (fail_tras) begin
                                    err_set      = 1'b1;
                                    err_set_code = ERR_TRAS;
                                end else begin
                                    do_pre = 1'b1;
                                end
                            end
                        end
                        default: begin
                            err_set      = 1'b1;
                            err_set_code = ERR_PAIRING;
                        end
                    endcase
                end
            end
            ST_GAP: begin
                if (cmd_valid) begin
                    err_set      = 1'b1;
                    err_set_code = ERR_PAIRING;
                    state_next   = ST_IDLE;
                end else begin
                    state_next = ST_EXPECT;
                end
            end
            ST_EXPECT: begin
                state_next = ST_IDLE;
                if (pair_match) begin
                    if (cap_code_reg == CMD_ACT0) begin
                        do_act = 1'b1;
                    end else if (cap_code_reg == CMD_RD0) begin
                        if (q_room) begin
                            do_push = 1'b1;
                        end else begin
                            err_set      = 1'b1;
                            err_set_code = ERR_RDQ_FULL;
                        end
                    end
                end else begin
                    err_set      = 1'b1;
                    err_set_code = ERR_PAIRING;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register, cycle counter and registered error pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            now_reg       <= '0;
            err_valid_reg <= 1'b0;
            err_code_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            now_reg       <= now_reg + 32'd1;
            err_valid_reg <= err_set;
            err_code_reg  <= err_set ? err_set_code : 4'd0;
        end
    end

    // Capture the first half of a pair
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cap_code_reg <= '0;
            cap_core_reg <= '0;
            cap_bg_reg   <= '0;
            cap_ba_reg   <= '0;
            cap_row_reg  <= '0;
            cap_col_reg  <= '0;
            cap_t_reg    <= '0;
        end else if (do_capture) begin
            cap_code_reg <= cmd_code;
            cap_core_reg <= cmd_core;
            cap_bg_reg   <= cmd_bg;
            cap_ba_reg   <= cmd_ba;
            cap_row_reg  <= cmd_row;
            cap_col_reg  <= cmd_col;
            cap_t_reg    <= now_reg;
        end
    end

    // Bank open bits and timestamp valid flags
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bank_open_reg <= '0;
            act0_vld_reg  <= '0;
            act1_vld_reg  <= '0;
            pre_vld_reg   <= '0;
            last_act_reg  <= '0;
            last_bg_reg   <= '0;
            last_vld_reg  <= 1'b0;
        end else begin
            if (do_act) begin
                bank_open_reg[cap_idx] <= 1'b1;
                act0_vld_reg[cap_idx]  <= 1'b1;
                act1_vld_reg[cap_idx]  <= 1'b1;
                last_act_reg           <= cap_t_reg;
                last_bg_reg            <= cap_bg_reg;
                last_vld_reg           <= 1'b1;
            end
            if (do_pre) begin
                bank_open_reg[cmd_idx] <= 1'b0;
                pre_vld_reg[cmd_idx]   <= 1'b1;
            end
        end
    end

    // Per-bank timestamp and row storage; qualified by the valid flags
    always_ff @(posedge clock) begin
        if (do_act) begin
            act0_stamp[cap_idx] <= cap_t_reg;
            act1_stamp[cap_idx] <= cap_t_reg + 32'd2;
            open_row[cap_idx]   <= cap_row_reg;
        end
        if (do_pre) begin
            pre_stamp[cmd_idx] <= now_reg;
        end
    end

    // Read queue pointers and occupancy
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (do_push)
                tail_reg <= ptr_inc(tail_reg);
            if (q_pop)
                head_reg <= ptr_inc(head_reg);
            case ({do_push, q_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Read queue payload, written at the RD1 edge
    always_ff @(posedge clock) begin
        if (do_push) begin
            q_core[tail_reg] <= cap_core_reg;
            q_bg[tail_reg]   <= cap_bg_reg;
            q_ba[tail_reg]   <= cap_ba_reg;
            q_col[tail_reg]  <= cap_col_reg;
            q_due[tail_reg]  <= cap_t_reg + TCAS;
        end
    end

    assign rd_valid  = q_pop;
    assign rd_core   = q_pop ? q_core[head_reg] : 4'd0;
    assign rd_bg     = q_pop ? q_bg[head_reg]   : 3'd0;
    assign rd_ba     = q_pop ? q_ba[head_reg]   : 2'd0;
    assign rd_col    = q_pop ? q_col[head_reg]  : 10'd0;
    assign err_valid = err_valid_reg;
    assign err_code  = err_code_reg;
    assign bank_open = bank_open_reg;

endmodule

// File: tb/tb_ddr5_cmd_responder.sv
// Testbench for ddr5_cmd_responder: directed scenarios plus a randomized
// command stream, all compared cycle by cycle against a time-based model.
module tb_ddr5_cmd_responder;

    logic        clock;
    logic        reset_n;
    logic        cmd_valid;
    logic [2:0]  cmd_code;
    logic [3:0]  cmd_core;
    logic [2:0]  cmd_bg;
    logic [1:0]  cmd_ba;
    logic [15:0] cmd_row;
    logic [9:0]  cmd_col;
    logic        rd_valid;
    logic [3:0]  rd_core;
    logic [2:0]  rd_bg;
    logic [1:0]  rd_ba;
    logic [9:0]  rd_col;
    logic        err_valid;
    logic [3:0]  err_code;
    logic [31:0] bank_open;

    ddr5_cmd_responder dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_core  (cmd_core),
        .cmd_bg    (cmd_bg),
        .cmd_ba    (cmd_ba),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .rd_valid  (rd_valid),
        .rd_core   (rd_core),
        .rd_bg     (rd_bg),
        .rd_ba     (rd_ba),
        .rd_col    (rd_col),
        .err_valid (err_valid),
        .err_code  (err_code),
        .bank_open (bank_open)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Timing rules, written down independently of the design
    localparam int T_RCD = 39, T_RAS = 76, T_RP = 39, T_RRD_L = 12, T_RRD_S = 8;
    localparam int T_CAS = 40, Q_DEPTH = 4;

    int n_pass = 0, n_total = 0, n_fail = 0;

    // Reference model state: absolute cycle times, -1 meaning "never"
    int          mnow;
    logic [31:0] m_open;
    int          m_act0 [32];
    int          m_act1 [32];
    int          m_pre  [32];
    int          m_last, m_last_bg;
    int          p_t, p_code, p_core, p_bg, p_ba, p_col;
    bit          exp_err_v;
    int          exp_err_c;

    typedef struct {
        int core;
        int bg;
        int ba;
        int col;
        int due;
    } rd_t;
    rd_t rq[$];

    // Observed events, used for the fixed expectations of each scenario
    int obs_err_n, obs_err_code, obs_err_t;
    int obs_rd_n, obs_rd_col, obs_rd_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s t=%0d observed 0x%0h expected 0x%0h", tag, mnow, obs, exp);
        end
    endtask

    task automatic model_clear();
        mnow      = 0;
        m_open    = '0;
        for (int i = 0; i < 32; i++) begin
            m_act0[i] = -1;
            m_act1[i] = -1;
            m_pre[i]  = -1;
        end
        m_last    = -1;
        m_last_bg = 0;
        p_t       = -1;
        exp_err_v = 1'b0;
        exp_err_c = 0;
        rq.delete();
        obs_err_n = 0; obs_err_code = 0; obs_err_t = -1;
        obs_rd_n  = 0; obs_rd_col   = 0; obs_rd_t  = -1;
    endtask

    task automatic set_err(input int code);
        exp_err_v = 1'b1;
        exp_err_c = code;
    endtask

    // One clock cycle: check outputs of cycle mnow, drive this cycle's
    // command, advance the model, then move to the next cycle.
    task automatic step(input bit v, input int code, input int core,
                        input int bg, input int ba, input int row, input int col);
        bit          exp_rv;
        logic [18:0] exp_fields;
        int          idx;
        exp_rv     = (rq.size() > 0) && (rq[0].due == mnow);
        exp_fields = exp_rv ? {4'(rq[0].core), 3'(rq[0].bg), 2'(rq[0].ba), 10'(rq[0].col)} : '0;
        chk("err_valid", 32'(err_valid), 32'(exp_err_v));
        chk("err_code", 32'(err_code), 32'(exp_err_c));
        chk("rd_valid", 32'(rd_valid), 32'(exp_rv));
        chk("rd_fields", 32'({rd_core, rd_bg, rd_ba, rd_col}), 32'(exp_fields));
        chk("bank_open", bank_open, m_open);
        if (err_valid === 1'b1) begin
            obs_err_n++;
            obs_err_code = int'(err_code);
            obs_err_t    = mnow;
            $display("t=%0d err code=%0d", mnow, err_code);
        end
        if (rd_valid === 1'b1) begin
            obs_rd_n++;
            obs_rd_col = int'(rd_col);
            obs_rd_t   = mnow;
            $display("t=%0d rd core=%0d bg=%0d ba=%0d col=0x%0h", mnow, rd_core, rd_bg, rd_ba, rd_col);
        end
        if (exp_rv)
            void'(rq.pop_front());

        cmd_valid = v;
        cmd_code  = 3'(code);
        cmd_core  = 4'(core);
        cmd_bg    = 3'(bg);
        cmd_ba    = 2'(ba);
        cmd_row   = 16'(row);
        cmd_col   = 10'(col);

        exp_err_v = 1'b0;
        exp_err_c = 0;
        idx       = bg * 4 + ba;
        if (p_t >= 0 && mnow == p_t + 1) begin
            // The cycle after a first half must be empty
            if (v) begin
                set_err(4);
                p_t = -1;
            end
        end else if (p_t >= 0 && mnow == p_t + 2) begin
            if (v && code == p_code + 1 && bg == p_bg && ba == p_ba && core == p_core) begin
                if (p_code == 0) begin
                    m_open[p_bg*4+p_ba] = 1'b1;
                    m_act0[p_bg*4+p_ba] = p_t;
                    m_act1[p_bg*4+p_ba] = p_t + 2;
                    m_last              = p_t;
                    m_last_bg           = p_bg;
                end else if (p_code == 2) begin
                    if (rq.size() >= Q_DEPTH)
                        set_err(8);
                    else
                        rq.push_back('{p_core, p_bg, p_ba, p_col, p_t + T_CAS});
                end
            end else begin
                set_err(4);
            end
            p_t = -1;
        end else if (v) begin
            if (code == 0) begin
                if (m_open[idx])
                    set_err(1);
                else if (m_pre[idx] >= 0 && mnow - m_pre[idx] < T_RP)
                    set_err(2);
                else if (m_last >= 0 && mnow - m_last < ((bg == m_last_bg) ? T_RRD_L : T_RRD_S))
                    set_err(3);
                else begin
                    p_t = mnow; p_code = code; p_core = core; p_bg = bg; p_ba = ba; p_col = col;
                end
            end else if (code == 2 || code == 4) begin
                if (!m_open[idx])
                    set_err(5);
                else if (m_act1[idx] >= 0 && mnow - m_act1[idx] < T_RCD)
                    set_err(6);
                else begin
                    p_t = mnow; p_code = code; p_core = core; p_bg = bg; p_ba = ba; p_col = col;
                end
            end else if (code == 6) begin
                if (m_open[idx]) begin
                    if (mnow - m_act0[idx] < T_RAS)
                        set_err(7);
                    else begin
                        m_open[idx] = 1'b0;
                        m_pre[idx]  = mnow;
                    end
                end
            end else begin
                set_err(4);
            end
        end

        @(negedge clock);
        mnow++;
    endtask

    task automatic idle_to(input int t);
        while (mnow < t)
            step(1'b0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cmd_at(input int t, input int code, input int bg, input int ba,
                          input int row, input int col, input int core);
        idle_to(t);
        step(1'b1, code, core, bg, ba, row, col);
    endtask

    task automatic act_at(input int t, input int bg, input int ba, input int row, input int core);
        cmd_at(t, 0, bg, ba, row, 0, core);
        cmd_at(t + 2, 1, bg, ba, row, 0, core);
    endtask

    task automatic rd_at(input int t, input int bg, input int ba, input int col, input int core);
        cmd_at(t, 2, bg, ba, 0, col, core);
        cmd_at(t + 2, 3, bg, ba, 0, col, core);
    endtask

    // Asynchronous reset, released on a falling edge so the next half
    // cycle is cycle 0 of the counter.
    task automatic do_reset();
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_code  = '0; cmd_core = '0; cmd_bg = '0; cmd_ba = '0;
        cmd_row   = '0; cmd_col  = '0;
        #1;
        chk("rst_bank_open", bank_open, 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_err_valid", 32'(err_valid), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        model_clear();
    endtask

    task automatic overflow_setup();
        for (int b = 0; b < 5; b++)
            act_at(10 + 10 * b, b, 0, 16'h0100 + b, b);
        for (int b = 0; b < 5; b++)
            rd_at(91 + 3 * b, b, 0, 10'h100 + b, b);
    endtask

    initial begin
        reset_n = 1'b0;
        @(negedge clock);
        do_reset();

        // Legal ACT / RD / PRE on bg2 ba1 (bank index 9)
        $display("scenario legal read");
        act_at(10, 2, 1, 16'h1A3C, 3);
        chk("s1_open_t13", 32'(bank_open[9]), 32'd1);
        rd_at(51, 2, 1, 10'h155, 3);
        idle_to(86);
        chk("s1_open_t86", 32'(bank_open[9]), 32'd1);
        cmd_at(86, 6, 2, 1, 0, 0, 3);
        chk("s1_closed_t87", 32'(bank_open[9]), 32'd0);
        idle_to(95);
        chk("s1_rd_count", obs_rd_n, 1);
        chk("s1_rd_time", obs_rd_t, 91);
        chk("s1_rd_col", obs_rd_col, 32'h155);
        chk("s1_err_count", obs_err_n, 0);

        // tRCD violation
        $display("scenario trcd");
        do_reset();
        act_at(10, 0, 0, 5, 1);
        cmd_at(40, 2, 0, 0, 0, 10'h2A, 1);
        idle_to(100);
        chk("s2_err_code", obs_err_code, 6);
        chk("s2_err_time", obs_err_t, 41);
        chk("s2_rd_count", obs_rd_n, 0);

        // tRRD within one bank group, then across bank groups
        $display("scenario trrd");
        do_reset();
        act_at(10, 3, 0, 7, 2);
        cmd_at(20, 0, 3, 1, 8, 0, 2);
        idle_to(25);
        chk("s3_err_code", obs_err_code, 3);
        chk("s3_err_time", obs_err_t, 21);
        do_reset();
        act_at(10, 3, 0, 7, 2);
        act_at(20, 4, 0, 8, 2);
        idle_to(25);
        chk("s3_err_count", obs_err_n, 0);
        chk("s3_open_both", bank_open, (32'd1 << 12) | (32'd1 << 16));

        // Missing second half, then a stray second half
        $display("scenario pairing");
        do_reset();
        cmd_at(10, 0, 1, 2, 9, 0, 4);
        idle_to(14);
        chk("s4_err_code", obs_err_code, 4);
        chk("s4_err_time", obs_err_t, 13);
        chk("s4_closed", bank_open, 32'd0);
        cmd_at(20, 3, 1, 2, 0, 0, 4);
        idle_to(22);
        chk("s4_stray_code", obs_err_code, 4);
        chk("s4_stray_time", obs_err_t, 21);

        // tRAS then tRP on bg5 ba2 (bank index 22)
        $display("scenario tras trp");
        do_reset();
        act_at(10, 5, 2, 11, 6);
        cmd_at(80, 6, 5, 2, 0, 0, 6);
        idle_to(82);
        chk("s5_tras_code", obs_err_code, 7);
        chk("s5_still_open", 32'(bank_open[22]), 32'd1);
        cmd_at(86, 6, 5, 2, 0, 0, 6);
        cmd_at(116, 0, 5, 2, 12, 0, 6);
        idle_to(118);
        chk("s5_trp_code", obs_err_code, 2);
        chk("s5_trp_time", obs_err_t, 117);
        chk("s5_err_count", obs_err_n, 2);

        // Five reads against a four-deep return queue
        $display("scenario overflow");
        do_reset();
        overflow_setup();
        idle_to(150);
        chk("s6_err_code", obs_err_code, 8);
        chk("s6_err_time", obs_err_t, 106);
        chk("s6_rd_count", obs_rd_n, 4);
        chk("s6_last_rd_t", obs_rd_t, 140);
        chk("s6_last_col", obs_rd_col, 32'h103);

        // Reset while reads are pending
        $display("scenario reset with pending reads");
        do_reset();
        overflow_setup();
        idle_to(120);
        do_reset();
        idle_to(200);
        chk("s7_rd_count", obs_rd_n, 0);
        chk("s7_bank_open", bank_open, 32'd0);

        // Randomized command stream on a few banks
        $display("scenario random");
        do_reset();
        for (int n = 0; n < 2500; n++) begin
            int r, code, core, bg, ba;
            r    = int'($urandom_range(99));
            core = int'($urandom_range(15));
            bg   = int'($urandom_range(2));
            ba   = int'($urandom_range(1));
            if (p_t >= 0 && mnow == p_t + 2 && r < 85) begin
                step(1'b1, p_code + 1, p_core, p_bg, p_ba, 0, p_col);
            end else if (p_t >= 0 && mnow == p_t + 1 && r < 92) begin
                step(1'b0, 0, 0, 0, 0, 0, 0);
            end else if (r < 25) begin
                case ($urandom_range(9))
                    0, 1, 2: code = 0;
                    3, 4, 5: code = 2;
                    6:       code = 4;
                    7, 8:    code = 6;
                    default: code = int'($urandom_range(7));
                endcase
                step(1'b1, code, core, bg, ba, int'($urandom_range(65535)), int'($urandom_range(1023)));
            end else begin
                step(1'b0, 0, 0, 0, 0, 0, 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
